// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master single-slave bus arbiter.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Returned to a master whose slave transfer timed out.
   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout.sv
// Grant-cycle counter: counts while enabled, flags when it reaches the limit.
module bus_timeout (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] limit,
   output logic       expired
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == limit);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter letting two masters share one slave, with per-grant timeout.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_cmd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_cmd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_err,
   output logic          s_req,
   output logic          s_cmd,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic          s_ack,
   input  logic [DW-1:0] s_rdata,
   output logic [1:0]    gnt
);

   localparam logic [7:0]    LIMIT    = 8'(TIMEOUT - 1);
   localparam logic [DW-1:0] ERR_WORD = DW'(ERR_RDATA);

   arb_state_t state, state_next;
   logic       last_served, last_next;
   logic       granted, sel_m1, cur_req, expired, timeout_hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
      end else begin
         state       <= state_next;
         last_served <= last_next;
      end
   end

   assign granted     = (state != IDLE);
   assign sel_m1      = (state == GNT1);
   assign cur_req     = sel_m1 ? m1_req : m0_req;
   // A same-cycle ack wins over the timeout, and an aborting master gets no error.
   assign timeout_hit = granted && expired && !s_ack && cur_req;

   bus_timeout u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (!granted || s_ack),
      .en      (granted && !s_ack),
      .limit   (LIMIT),
      .expired (expired)
   );

   always_comb begin
      state_next = state;
      last_next  = last_served;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_next = last_served ? GNT0 : GNT1;
            end else if (m0_req) begin
               state_next = GNT0;
            end else if (m1_req) begin
               state_next = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (s_ack || timeout_hit) begin
               state_next = IDLE;
               last_next  = sel_m1;
            end else if (!cur_req) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      s_req    = 1'b0;
      s_cmd    = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      m0_ack   = 1'b0;
      m0_rdata = '0;
      m0_err   = 1'b0;
      m1_ack   = 1'b0;
      m1_rdata = '0;
      m1_err   = 1'b0;
      gnt      = 2'b00;
      case (state)
         GNT0: begin
            gnt      = 2'b01;
            s_req    = m0_req;
            s_cmd    = m0_cmd;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            m0_ack   = s_ack || timeout_hit;
            m0_rdata = timeout_hit ? ERR_WORD : s_rdata;
            m0_err   = timeout_hit;
         end
         GNT1: begin
            gnt      = 2'b10;
            s_req    = m1_req;
            s_cmd    = m1_cmd;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            m1_ack   = s_ack || timeout_hit;
            m1_rdata = timeout_hit ? ERR_WORD : s_rdata;
            m1_err   = timeout_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: handshake, round-robin, timeout, abort, reset.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_cmd, m0_ack, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_cmd, m1_ack, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        s_req, s_cmd, s_ack;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  gnt;

   int errors = 0;
   int checks = 0;

   bus_arbiter #(.DW(32), .AW(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata), .gnt(gnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input logic r0, input logic [31:0] a0,
                                 input logic r1, input logic [31:0] a1,
                                 input logic ack, input logic [31:0] rdata);
      m0_req  = r0;
      m0_addr = a0;
      m1_req  = r1;
      m1_addr = a1;
      s_ack   = ack;
      s_rdata = rdata;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      m0_cmd = 1'b0; m0_wdata = '0; m1_cmd = 1'b0; m1_wdata = '0;
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      apply_stimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_output("reset_gnt", gnt, 2'b00);
      check_output("reset_s_req", s_req, 1'b0);
      check_output("reset_m0_ack", m0_ack, 1'b0);
      check_output("reset_m0_rdata", m0_rdata, 32'h0);
      check_output("reset_m1_err", m1_err, 1'b0);

      // Single master write, slave acks in the third grant cycle
      rst = 1'b1;
      m0_cmd = 1'b1; m0_wdata = 32'hA5A5_0001;
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      apply_stimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("w_idle_s_req", s_req, 1'b0);
      tick();
      check_output("w_gnt", gnt, 2'b01);
      check_output("w_s_req", s_req, 1'b1);
      check_output("w_s_cmd", s_cmd, 1'b1);
      check_output("w_s_addr", s_addr, 32'h10);
      check_output("w_s_wdata", s_wdata, 32'hA5A5_0001);
      check_output("w_m0_ack_c1", m0_ack, 1'b0);
      tick();
      check_output("w_m0_ack_c2", m0_ack, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h0);
      check_output("w_m0_ack_c3", m0_ack, 1'b1);
      check_output("w_m1_ack", m1_ack, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("w_gnt_after", gnt, 2'b00);
      check_output("w_m0_ack_after", m0_ack, 1'b0);

      // Ack while idle must be ignored
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h55);
      check_output("idle_ack_m0", m0_ack, 1'b0);
      check_output("idle_ack_m1_rdata", m1_rdata, 32'h0);
      tick();
      check_output("idle_ack_gnt", gnt, 2'b00);

      // Re-reset so master 0 wins the first tie
      rst = 1'b0;
      m0_cmd = 1'b0; m0_wdata = '0;
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
      apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      tick();
      check_output("tie1_gnt", gnt, 2'b01);
      check_output("tie1_s_addr", s_addr, 32'h100);
      apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h11);
      check_output("tie1_m0_rdata", m0_rdata, 32'h11);
      check_output("tie1_m1_ack", m1_ack, 1'b0);
      check_output("tie1_m1_rdata", m1_rdata, 32'h0);
      tick();
      apply_stimulus(1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
      check_output("tie1_bubble", gnt, 2'b00);
      tick();
      check_output("tie2_gnt", gnt, 2'b10);
      check_output("tie2_s_addr", s_addr, 32'h200);
      apply_stimulus(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 32'h22);
      check_output("tie2_m1_rdata", m1_rdata, 32'h22);
      check_output("tie2_m0_ack", m0_ack, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h104, 1'b1, 32'h204, 1'b0, 32'h0);
      check_output("tie2_bubble", gnt, 2'b00);
      tick();
      check_output("tie3_gnt", gnt, 2'b01);
      check_output("tie3_s_addr", s_addr, 32'h104);
      apply_stimulus(1'b1, 32'h104, 1'b1, 32'h204, 1'b1, 32'h33);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0);
      check_output("tie3_bubble", gnt, 2'b00);
      tick();
      check_output("tie4_gnt", gnt, 2'b10);
      check_output("tie4_s_addr", s_addr, 32'h204);
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h44);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("tie4_done", gnt, 2'b00);

      // Master 1 read with a silent slave times out in grant cycle 16
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
      tick();
      for (int i = 1; i <= 15; i++) begin
         check_output($sformatf("to_m1_ack_c%0d", i), m1_ack, 1'b0);
         tick();
      end
      check_output("to_gnt_c16", gnt, 2'b10);
      check_output("to_m1_ack_c16", m1_ack, 1'b1);
      check_output("to_m1_err_c16", m1_err, 1'b1);
      check_output("to_m1_rdata_c16", m1_rdata, 32'hDEAD_BEEF);
      check_output("to_m0_ack_c16", m0_ack, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("to_gnt_after", gnt, 2'b00);
      check_output("to_m1_err_after", m1_err, 1'b0);

      // Ack arriving in the timeout cycle is a normal completion
      apply_stimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      for (int i = 1; i <= 15; i++) begin
         if (i == 15) check_output("race_m0_err_c15", m0_err, 1'b0);
         tick();
      end
      apply_stimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      check_output("race_m0_ack", m0_ack, 1'b1);
      check_output("race_m0_err", m0_err, 1'b0);
      check_output("race_m0_rdata", m0_rdata, 32'h1234_5678);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("race_gnt_after", gnt, 2'b00);

      // Abort: master 0 drops req in grant cycle 2; last_served must stay at 1
      rst = 1'b0;
      tick();
      rst = 1'b1;
      apply_stimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_output("ab_gnt_c1", gnt, 2'b01);
      tick();
      apply_stimulus(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("ab_s_req_c2", s_req, 1'b0);
      check_output("ab_m0_ack_c2", m0_ack, 1'b0);
      tick();
      check_output("ab_gnt_idle", gnt, 2'b00);
      apply_stimulus(1'b1, 32'h44, 1'b1, 32'h48, 1'b0, 32'h0);
      tick();
      check_output("ab_tie_gnt", gnt, 2'b01);
      apply_stimulus(1'b1, 32'h44, 1'b1, 32'h48, 1'b1, 32'h0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();

      // Reset in the middle of a master 1 grant
      apply_stimulus(1'b0, 32'h0, 1'b1, 32'h50, 1'b0, 32'h0);
      tick();
      check_output("mr_s_req_before", s_req, 1'b1);
      rst = 1'b0;
      tick();
      check_output("mr_s_req", s_req, 1'b0);
      check_output("mr_gnt", gnt, 2'b00);
      check_output("mr_m1_ack", m1_ack, 1'b0);
      tick();
      check_output("mr_s_req_hold", s_req, 1'b0);
      rst = 1'b1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DW, default 32, data width.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter TIMEOUT, default 16, max cycles in a grant state waiting for s_ack; legal range 2..255.
REQ-004 Ports SHALL be exactly: clk input 1 clock; rst input 1 reset; m0_req input 1; m0_cmd input 1 (1=write, 0=read); m0_addr input AW; m0_wdata input DW; m0_ack output 1; m0_rdata output DW; m0_err output 1; m1_req, m1_cmd, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err identical for master 1; s_req output 1; s_cmd output 1; s_addr output AW; s_wdata output DW; s_ack input 1; s_rdata input DW; gnt output 2 (one-hot current owner, 2'b00 when idle).
REQ-005 The block SHALL use one clock (clk, rising edge); reset (rst) is synchronous and active-low.

Function
REQ-006 FSM states SHALL be IDLE, GNT0 and GNT1; gnt SHALL be 2'b01 in GNT0, 2'b10 in GNT1 and 2'b00 in IDLE.
REQ-007 IDLE with only mN_req=1 SHALL move to GNTN on the next edge.
REQ-008 IDLE with both requests high SHALL grant the master not served last (round-robin); last_served SHALL be 1 after reset, so master 0 wins the first tie.
REQ-009 IDLE with no request SHALL stay in IDLE.
REQ-010 In GNTN, s_req/s_cmd/s_addr/s_wdata SHALL combinationally equal mN_req/cmd/addr/wdata; outside any grant, all s_* outputs SHALL be 0.
REQ-011 In GNTN, mN_ack SHALL equal s_ack and mN_rdata SHALL equal s_rdata; the non-granted master SHALL see ack=0, rdata=0, err=0.
REQ-012 On s_ack=1 in GNTN, the FSM SHALL return to IDLE, last_served SHALL become N, and the timeout counter SHALL clear.
REQ-013 Latency: request to s_req SHALL be 1 cycle; the IDLE cycle after each ack SHALL be a mandatory one-cycle bubble, even with requests pending.
REQ-014 If mN_req drops in GNTN without s_ack (abort), the FSM SHALL return to IDLE on the next edge, and last_served SHALL NOT update.
REQ-015 An 8-bit counter SHALL count cycles in GNTN without s_ack; when it equals TIMEOUT-1 with s_ack=0, mN_ack=1, mN_err=1 and mN_rdata=32'hDEAD_BEEF SHALL be driven for that cycle, and the FSM SHALL go to IDLE with last_served=N.
REQ-016 s_ack and timeout in the same cycle SHALL resolve as a normal ack (err=0, slave rdata).
REQ-017 s_ack received in IDLE SHALL be ignored.
REQ-018 Masters SHALL hold req/cmd/addr/wdata stable until ack; the arbiter SHALL NOT register the request fields.

Reset
REQ-019 While rst=0 at a clk edge: state=IDLE, last_served=1 and counter=0.
REQ-020 During and after reset: gnt=0, every s_* output=0 and every mN_ack/mN_rdata/mN_err=0.
REQ-021 Reset asserted mid-grant SHALL abort the transfer without ack to the master; s_req SHALL be 0 from the first edge sampling rst=0.

Structure
REQ-022 Package bus_pkg SHALL hold the state enum, CMD_READ/CMD_WRITE constants and ERR_RDATA=32'hDEAD_BEEF.
REQ-023 The timeout counter SHALL be the sub-module bus_timeout (ports: clk, rst, clr, en, limit, expired).
REQ-024 The FSM, round-robin bit and routing muxes SHALL reside in bus_arbiter.

Verification
REQ-025 Single master: m0 writes addr=0x10, wdata=0xA5A5_0001, and the slave acks after 3 cycles -> s_req rises 1 cycle after m0_req, m0_ack pulses once, m1_ack stays 0, and gnt=01 then 00.
REQ-026 Tie: m0_req and m1_req both rise in the same cycle, each issuing 2 reads -> grant order m0, m1, m0, m1 with a 1-cycle IDLE between each.
REQ-027 Timeout: m1 reads addr=0x20, slave never acks, TIMEOUT=16 -> m1_ack=1, m1_err=1, m1_rdata=0xDEAD_BEEF in the 16th grant cycle, then gnt=00.
REQ-028 Same-cycle ack and timeout: slave acks in cycle 16 with rdata=0x1234_5678 -> m0_err=0 and m0_rdata=0x1234_5678.
REQ-029 Abort and reset: m0 drops req in cycle 2 of its grant -> IDLE next cycle and m0 wins the next tie; separately, rst=0 mid-grant -> s_req=0 at the next edge and no ack pulse.
